sysid_verify_ctrl: RTL and testbench

Avalon-MM master that sequences reads of the Qsys system-ID slave (word 0 = system ID, word 1 = build timestamp) and checks both against expected values fixed at build time. It sits beside the sysid peripheral in the StepperMotorControl system. Its `match` output gates motor-driver enable, so firmware/hardware mismatches never drive the stepper.

---
 rtl/sysid_verify_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sysid_verify_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_verify_ctrl.sv
// Avalon-MM master that reads the system-ID slave (ID, then timestamp) and checks both words.
// Optional per-read stall abort is compiled in with `define SYSID_VERIFY_TIMEOUT_EN.
module sysid_verify_ctrl #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0400_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5446_27C2,
    parameter int unsigned READ_LATENCY       = 0,
    parameter bit          AUTO_START         = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_LAT_ID,
        S_RD_TS,
        S_LAT_TS,
        S_EVAL
    } state_e;

    localparam logic [1:0] LAT_LOAD = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_e      state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic        auto_q;
    logic        done_q, id_ok_q, ts_ok_q, match_q;
    logic [31:0] id_value_q, ts_value_q;
    logic        launch, accept, timeout_hit, cap_id, cap_ts;

    assign launch = start | auto_q;
    assign accept = avm_read & ~avm_waitrequest;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cap_id  = 1'b0;
        cap_ts  = 1'b0;
        case (state_q)
            S_IDLE: if (launch) state_d = S_RD_ID;
            S_RD_ID: begin
                if (timeout_hit) begin
                    state_d = S_EVAL;
                end else if (accept) begin
                    if (READ_LATENCY == 0) begin
                        cap_id  = 1'b1;
                        state_d = S_RD_TS;
                    end else begin
                        lat_d   = LAT_LOAD;
                        state_d = S_LAT_ID;
                    end
                end
            end
            S_LAT_ID: begin
                if (lat_q == '0) begin
                    cap_id  = 1'b1;
                    state_d = S_RD_TS;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_RD_TS: begin
                if (timeout_hit) begin
                    state_d = S_EVAL;
                end else if (accept) begin
                    if (READ_LATENCY == 0) begin
                        cap_ts  = 1'b1;
                        state_d = S_EVAL;
                    end else begin
                        lat_d   = LAT_LOAD;
                        state_d = S_LAT_TS;
                    end
                end
            end
            S_LAT_TS: begin
                if (lat_q == '0) begin
                    cap_ts  = 1'b1;
                    state_d = S_EVAL;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_EVAL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_RD_ID: avm_read = 1'b1;
            S_RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
            end
            default: ;
        endcase
    end

    // auto_q is set only while in reset, so it can fire at most once, on the first free cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_q     <= AUTO_START;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            match_q    <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            auto_q <= 1'b0;
            done_q <= (state_q == S_EVAL);
            if (state_q == S_IDLE && launch) begin
                id_ok_q    <= 1'b0;
                ts_ok_q    <= 1'b0;
                match_q    <= 1'b0;
                id_value_q <= '0;
                ts_value_q <= '0;
            end
            if (cap_id) id_value_q <= avm_readdata;
            if (cap_ts) ts_value_q <= avm_readdata;
            if (state_q == S_EVAL) begin
                id_ok_q <= ~timeout & (id_value_q == EXPECTED_ID);
                ts_ok_q <= ~timeout & (ts_value_q == EXPECTED_TIMESTAMP);
                match_q <= ~timeout & (id_value_q == EXPECTED_ID)
                                    & (ts_value_q == EXPECTED_TIMESTAMP);
            end
        end
    end

`ifdef SYSID_VERIFY_TIMEOUT_EN
    logic [31:0] to_cnt_q;
    logic        timeout_q;

    // Stalls within one read are contiguous, so clearing on any non-stall cycle restarts per read
    assign timeout_hit = avm_read & avm_waitrequest & (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q <= (avm_read & avm_waitrequest) ? to_cnt_q + 32'd1 : '0;
            if (state_q == S_IDLE && launch) timeout_q <= 1'b0;
            else if (timeout_hit)            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign done     = done_q;
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign match    = match_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// Scoreboard bench for sysid_verify_ctrl: instance A uses defaults (auto-start, latency 0),
// instance B uses latency 2, no auto-start and a 16-cycle stall limit.
module tb_sysid_verify_ctrl;

    localparam logic [31:0] ID    = 32'h0400_0000;
    localparam logic [31:0] TS    = 32'h5446_27C2;
    localparam logic [31:0] TSBAD = 32'h5446_27C3;
    localparam int unsigned LB    = 2;

    typedef struct {
        logic        idok;
        logic        tsok;
        logic        mt;
        logic        to;
        logic [31:0] idv;
        logic [31:0] tsv;
        int unsigned cyc;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t qa[$];
    exp_t qb[$];
    int pushed_a = 0, pushed_b = 0, done_cnt_a = 0, done_cnt_b = 0;

    // Instance A signals
    logic        rst_a, start_a, wr_a, rd_a, ad_a, busy_a, done_a;
    logic        idok_a, tsok_a, match_a, to_a;
    logic [31:0] rdata_a, idv_a, tsv_a, id_a, ts_a;
    // Instance B signals
    logic        rst_b, start_b, wr_b, rd_b, ad_b, busy_b, done_b;
    logic        idok_b, tsok_b, match_b, to_b;
    logic [31:0] rdata_b, idv_b, tsv_b, id_b, ts_b;

    sysid_verify_ctrl #(
        .EXPECTED_ID(ID), .EXPECTED_TIMESTAMP(TS), .READ_LATENCY(0),
        .AUTO_START(1'b1), .TIMEOUT_CYCLES(1024)
    ) u_a (
        .clock(clock), .reset(rst_a), .start(start_a),
        .avm_address(ad_a), .avm_read(rd_a), .avm_waitrequest(wr_a), .avm_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .id_ok(idok_a), .ts_ok(tsok_a), .match(match_a),
        .id_value(idv_a), .ts_value(tsv_a), .timeout(to_a)
    );

    sysid_verify_ctrl #(
        .EXPECTED_ID(ID), .EXPECTED_TIMESTAMP(TS), .READ_LATENCY(LB),
        .AUTO_START(1'b0), .TIMEOUT_CYCLES(16)
    ) u_b (
        .clock(clock), .reset(rst_b), .start(start_b),
        .avm_address(ad_b), .avm_read(rd_b), .avm_waitrequest(wr_b), .avm_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .id_ok(idok_b), .ts_ok(tsok_b), .match(match_b),
        .id_value(idv_b), .ts_value(tsv_b), .timeout(to_b)
    );

    // Slave A: zero latency, data follows the address combinationally
    assign rdata_a = ad_a ? ts_a : id_a;

    // Slave B: data valid only in the last latency cycle after accept, garbage otherwise
    logic [1:0] pend_b;
    logic       pend_addr_b;
    always @(posedge clock) begin
        if (rst_b) begin
            pend_b      <= 2'd0;
            pend_addr_b <= 1'b0;
        end else if (rd_b && !wr_b) begin
            pend_b      <= 2'(LB);
            pend_addr_b <= ad_b;
        end else if (pend_b != 2'd0) begin
            pend_b <= pend_b - 2'd1;
        end
    end
    assign rdata_b = (pend_b == 2'd1) ? (pend_addr_b ? ts_b : id_b) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic check_done(input string tag, input exp_t e, input int unsigned now,
                              input logic bsy, input logic oi, input logic ot, input logic mt,
                              input logic to, input logic [31:0] iv, input logic [31:0] tv);
        chk({tag, "_done_cycle"}, 96'(now), 96'(e.cyc));
        chk({tag, "_flags"}, {bsy, oi, ot, mt, to}, {1'b0, e.idok, e.tsok, e.mt, e.to});
        chk({tag, "_values"}, {iv, tv}, {e.idv, e.tsv});
    endtask

    // Monitor: every done pulse consumes one expected record
    always @(negedge clock) begin
        if (done_a) begin
            done_cnt_a++;
            if (qa.size() == 0) begin
                n_checks++;
                $display("FAIL a_unexpected_done: done at cycle %0d, nothing expected", cyc);
            end else begin
                check_done("a", qa.pop_front(), cyc, busy_a, idok_a, tsok_a, match_a, to_a, idv_a, tsv_a);
            end
        end
        if (done_b) begin
            done_cnt_b++;
            if (qb.size() == 0) begin
                n_checks++;
                $display("FAIL b_unexpected_done: done at cycle %0d, nothing expected", cyc);
            end else begin
                check_done("b", qb.pop_front(), cyc, busy_b, idok_b, tsok_b, match_b, to_b, idv_b, tsv_b);
            end
        end
    end

    task automatic exp_a(input logic i, input logic t, input logic m, input logic o,
                         input logic [31:0] iv, input logic [31:0] tv, input int unsigned dc);
        exp_t e;
        e = '{idok: i, tsok: t, mt: m, to: o, idv: iv, tsv: tv, cyc: dc};
        qa.push_back(e);
        pushed_a++;
    endtask

    task automatic exp_b(input logic i, input logic t, input logic m, input logic o,
                         input logic [31:0] iv, input logic [31:0] tv, input int unsigned dc);
        exp_t e;
        e = '{idok: i, tsok: t, mt: m, to: o, idv: iv, tsv: tv, cyc: dc};
        qb.push_back(e);
        pushed_b++;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 64; i++) begin
            if (qa.size() == 0) break;
            @(negedge clock);
        end
        chk("a_drain", 96'(qa.size()), 96'd0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 64; i++) begin
            if (qb.size() == 0) break;
            @(negedge clock);
        end
        chk("b_drain", 96'(qb.size()), 96'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned c;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        wr_a = 1'b0; wr_b = 1'b0;
        id_a = ID; ts_a = TS; id_b = ID; ts_b = TS;
        repeat (3) @(negedge clock);
        chk("a_reset", {busy_a, done_a, rd_a, ad_a, idok_a, tsok_a, match_a, to_a, idv_a, tsv_a}, '0);
        chk("b_reset", {busy_b, done_b, rd_b, ad_b, idok_b, tsok_b, match_b, to_b, idv_b, tsv_b}, '0);

        // A: auto-start on the first free cycle, good words
        c = cyc;
        exp_a(1'b1, 1'b1, 1'b1, 1'b0, ID, TS, c + 4);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clock);
        chk("a_auto_rd_id", {busy_a, rd_a, ad_a}, 3'b110);
        chk("b_no_auto", {busy_b, rd_b}, 2'b00);
        @(negedge clock);
        chk("a_rd_ts", {busy_a, rd_a, ad_a}, 3'b111);
        @(negedge clock);
        chk("a_eval", {busy_a, rd_a, done_a}, 3'b100);
        drain_a();

        // A: timestamp off by one
        ts_a = TSBAD;
        exp_a(1'b1, 1'b0, 1'b0, 1'b0, ID, TSBAD, cyc + 4);
        start_a = 1'b1; @(negedge clock); start_a = 1'b0;
        drain_a();

        // A: start in RD_TS ignored; start on the done cycle relaunches
        ts_a = TS;
        c = cyc;
        exp_a(1'b1, 1'b1, 1'b1, 1'b0, ID, TS, c + 4);
        start_a = 1'b1;
        @(negedge clock); start_a = 1'b0;
        @(negedge clock); start_a = 1'b1;
        @(negedge clock); start_a = 1'b0;
        @(negedge clock);
        start_a = 1'b1; ts_a = TSBAD;
        exp_a(1'b1, 1'b0, 1'b0, 1'b0, ID, TSBAD, c + 8);
        @(negedge clock); start_a = 1'b0;
        chk("a_relaunch_clear", {busy_a, idok_a, tsok_a, match_a, idv_a, tsv_a}, {1'b1, 3'b000, 64'h0});
        drain_a();
        ts_a = TS;

        // B: latency 2, no waitstates
        exp_b(1'b1, 1'b1, 1'b1, 1'b0, ID, TS, cyc + 8);
        start_b = 1'b1; @(negedge clock); start_b = 1'b0;
        drain_b();

        // B: three waitstates on the ID read
        c = cyc;
        exp_b(1'b1, 1'b1, 1'b1, 1'b0, ID, TS, c + 11);
        wr_b = 1'b1; start_b = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            start_b = 1'b0;
            chk("b_stall_hold", {busy_b, rd_b, ad_b}, 3'b110);
            if (k == 4) wr_b = 1'b0;
        end
        @(negedge clock);
        chk("b_lat_noread", {busy_b, rd_b}, 2'b10);
        drain_b();

        // B: reset while in LAT_ID
        start_b = 1'b1;
        @(negedge clock); start_b = 1'b0;
        @(negedge clock);
        chk("b_in_lat_id", {busy_b, rd_b}, 2'b10);
        rst_b = 1'b1;
        @(negedge clock);
        chk("b_rst_lat_id", {busy_b, done_b, rd_b, ad_b, idok_b, tsok_b, match_b, to_b, idv_b, tsv_b}, '0);
        rst_b = 1'b0;
        repeat (6) @(negedge clock);
        chk("b_idle_after_rst", {busy_b, rd_b}, 2'b00);

        // B: reset while in LAT_TS, after the ID word has been captured
        start_b = 1'b1;
        @(negedge clock); start_b = 1'b0;
        repeat (3) @(negedge clock);
        chk("b_id_captured", {rd_b, ad_b, idv_b}, {2'b11, ID});
        @(negedge clock);
        rst_b = 1'b1;
        @(negedge clock);
        chk("b_rst_lat_ts", {busy_b, done_b, rd_b, ad_b, idok_b, tsok_b, match_b, to_b, idv_b, tsv_b}, '0);
        rst_b = 1'b0;
        @(negedge clock);

`ifdef SYSID_VERIFY_TIMEOUT_EN
        // B: waitrequest stuck high aborts after 16 stalled cycles
        c = cyc;
        exp_b(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, c + 18);
        wr_b = 1'b1; start_b = 1'b1;
        @(negedge clock); start_b = 1'b0;
        repeat (15) @(negedge clock);
        chk("b_to_last_stall", {busy_b, rd_b}, 2'b11);
        @(negedge clock);
        chk("b_to_drop", {busy_b, rd_b, to_b}, 3'b101);
        wr_b = 1'b0;
        drain_b();
`endif

        // B: clean run after resets (and after any abort)
        exp_b(1'b1, 1'b1, 1'b1, 1'b0, ID, TS, cyc + 8);
        start_b = 1'b1; @(negedge clock); start_b = 1'b0;
        drain_b();

        repeat (4) @(negedge clock);
        chk("a_done_count", 96'(done_cnt_a), 96'(pushed_a));
        chk("b_done_count", 96'(done_cnt_b), 96'(pushed_b));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
